// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and constants for the 2x2 TPU sequencer.
//   tpu_state_t     : sequencer FSM states
//   TPU_N/DATA_W/ACC_W : default matrix size, operand width, result width
//   A_BASE/B_BASE   : operand buffer base addresses of matrices A and B
package tpu_pkg;
    localparam int TPU_N      = 2;
    localparam int TPU_DATA_W = 8;
    localparam int TPU_ACC_W  = 16;
    localparam int A_BASE     = 0;
    localparam int B_BASE     = 4;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_OUTPUT
    } tpu_state_t;
endpackage

// File: rtl/tpu_out_ser.sv
// tpu_out_ser: serializes the N*N array results, high byte first, over a valid/ready port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : freezes all state when low
//   start_i     : one-cycle pulse, begin streaming from result 0
//   out_ready   : host accepts the current byte
//   result_in   : selected array result (combinational from result_idx)
//   result_idx  : which result is being streamed
//   out_data    : current byte (0 while idle)
//   out_valid   : out_data is valid
//   last_o      : pulses in the cycle the final byte is accepted
// Build option TPU_RELU_EN: negative results are clamped to zero before byte selection.
module tpu_out_ser
    import tpu_pkg::*;
#(
    parameter int N      = TPU_N,
    parameter int DATA_W = TPU_DATA_W,
    parameter int ACC_W  = TPU_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start_i,
    input  logic                     out_ready,
    input  logic [ACC_W-1:0]         result_in,
    output logic [$clog2(N*N)-1:0]   result_idx,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     last_o
);
    localparam int CNT_W = $clog2(2*N*N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2*N*N-1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [ACC_W-1:0] res;
    logic             accept;

`ifdef TPU_RELU_EN
    assign res = result_in[ACC_W-1] ? '0 : result_in;
`else
    assign res = result_in;
`endif

    assign accept     = ena && active_q && out_ready;
    assign last_o     = accept && byte_cnt_q == LAST;
    assign out_valid  = active_q;
    assign result_idx = byte_cnt_q[CNT_W-1:1];
    assign out_data   = !active_q ? '0 : byte_cnt_q[0] ? res[DATA_W-1:0] : res[ACC_W-1:DATA_W];

    always_comb begin
        active_d   = start_i ? 1'b1 : last_o ? 1'b0 : active_q;
        byte_cnt_d = (start_i || last_o) ? '0 : accept ? byte_cnt_q + 1'b1 : byte_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            byte_cnt_q <= '0;
        end else if (ena) begin
            active_q   <= active_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end
endmodule

// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: load operands, clear/start the 2x2 systolic array, stream results out.
//   clk, rst_n, ena           : clock, asynchronous active-low reset, design enable
//   in_data, in_valid         : operand byte stream (8 bytes: A then B, row-major)
//   out_ready, out_data, out_valid : result byte stream, high byte first
//   busy, done                : not idle; one-cycle pulse after the last byte is accepted
//   mem_we, mem_addr, mem_wdata : registered operand buffer write port
//   array_clear, array_start, array_done : array control strobes and done level
//   result_idx, result_in     : result select and selected result
// Build option TPU_RELU_EN (see tpu_out_ser): clamp negative results to zero.
module tpu_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int N      = TPU_N,
    parameter int DATA_W = TPU_DATA_W,
    parameter int ACC_W  = TPU_ACC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_we,
    output logic [$clog2(2*N*N)-1:0]  mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      array_clear,
    output logic                      array_start,
    input  logic                      array_done,
    output logic [$clog2(N*N)-1:0]    result_idx,
    input  logic [ACC_W-1:0]          result_in
);
    localparam int AW = $clog2(2*N*N);
    localparam logic [AW-1:0] LAST = AW'(2*N*N-1);

    tpu_state_t        state_q;
    logic [AW-1:0]     load_cnt_q;
    logic              busy_q, done_q, mem_we_q, clear_q, start_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              ser_start, ser_last;

    assign ser_start   = ena && state_q == S_WAIT && array_done;
    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign array_clear = clear_q;
    assign array_start = start_q;

    // Strobe outputs default low each enabled cycle; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            clear_q     <= 1'b0;
            start_q     <= 1'b0;
        end else if (ena) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            clear_q     <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                // IDLE shares the write path: its first byte lands at load_cnt_q == 0.
                S_IDLE, S_LOAD: if (in_valid) begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= load_cnt_q;
                    mem_wdata_q <= in_data;
                    load_cnt_q  <= load_cnt_q + 1'b1;
                    busy_q      <= 1'b1;
                    clear_q     <= load_cnt_q == LAST;
                    state_q     <= load_cnt_q == LAST ? S_CLEAR : S_LOAD;
                end
                S_CLEAR: begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: state_q <= S_WAIT;
                S_WAIT:  if (array_done) state_q <= S_OUTPUT;
                S_OUTPUT: if (ser_last) begin
                    state_q    <= S_IDLE;
                    load_cnt_q <= '0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    tpu_out_ser #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start_i    (ser_start),
        .out_ready  (out_ready),
        .result_in  (result_in),
        .result_idx (result_idx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .last_o     (ser_last)
    );
endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb_tpu_seq_ctrl: scoreboard bench for tpu_seq_ctrl with a behavioural 2x2 array model.
module tb_tpu_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       array_done = 1'b0;
    logic [7:0] out_data, mem_wdata;
    logic       out_valid, busy, done, mem_we, array_clear, array_start;
    logic [2:0] mem_addr;
    logic [1:0] result_idx;
    logic [15:0] result_in;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    tpu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid), .busy(busy),
        .done(done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .array_clear(array_clear), .array_start(array_start), .array_done(array_done),
        .result_idx(result_idx), .result_in(result_in)
    );

    function automatic logic [15:0] mac(input logic [7:0] m[8], input int r);
        int i, j, c;
        i = r / 2;
        j = r % 2;
        c = $signed(m[2*i]) * $signed(m[4+j]) + $signed(m[2*i+1]) * $signed(m[6+j]);
        return c[15:0];
    endfunction

    // Array model: buffer captured from the write port, done 4 cycles after start.
    logic [7:0] amem[8];
    logic [2:0] acnt = '0;
    logic       arun = 1'b0;
    always @(posedge clk) begin
        if (mem_we) amem[mem_addr] <= mem_wdata;
        if (array_clear) begin
            array_done <= 1'b0;
            arun <= 1'b0;
        end else if (array_start) begin
            arun <= 1'b1;
            acnt <= 3'd1;
        end else if (arun) begin
            if (acnt == 3'd4) begin
                array_done <= 1'b1;
                arun <= 1'b0;
            end else acnt <= acnt + 3'd1;
        end
    end
    always_comb result_in = mac(amem, int'(result_idx));

    task automatic step;
        @(negedge clk);
    endtask

    task automatic push_bytes(input logic [7:0] b[8]);
        for (int k = 0; k < 8; k++) sb.push_back(b[k]);
    endtask

    task automatic push_model(input logic [7:0] ops[8]);
        logic [15:0] c;
        for (int r = 0; r < 4; r++) begin
            c = mac(ops, r);
`ifdef TPU_RELU_EN
            if (c[15]) c = '0;
`endif
            sb.push_back(c[15:8]);
            sb.push_back(c[7:0]);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({out_data, out_valid, busy, done, mem_we, mem_addr, mem_wdata, array_clear,
             array_start, result_idx} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs not all zero (out_data=%h out_valid=%b busy=%b done=%b mem_we=%b clr=%b start=%b idx=%0d)",
                     name, out_data, out_valid, busy, done, mem_we, array_clear, array_start, result_idx);
        end
    endtask

    task automatic load_ops(input logic [7:0] ops[8], input int gap, input int pause_at);
        for (int k = 0; k < 8; k++) begin
            if (k == pause_at) begin
                logic [12:0] snap;
                snap = {busy, mem_we, mem_addr, mem_wdata};
                ena = 1'b0;
                in_valid = 1'b1;
                in_data = 8'hEE;
                for (int p = 0; p < 5; p++) begin
                    step();
                    n_checks++;
                    if ({busy, mem_we, mem_addr, mem_wdata} !== snap) begin
                        n_fail++;
                        $display("FAIL load_ena_hold: got %h want %h", {busy, mem_we, mem_addr, mem_wdata}, snap);
                    end
                end
                in_valid = 1'b0;
                ena = 1'b1;
            end
            in_valid = 1'b1;
            in_data = ops[k];
            step();
            in_valid = 1'b0;
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 3'(k) || mem_wdata !== ops[k]) begin
                n_fail++;
                $display("FAIL load_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         k, mem_we, mem_addr, mem_wdata, k, ops[k]);
            end
            if (k < 7) for (int g = 1; g < gap; g++) begin
                step();
                n_checks++;
                if (mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_gap: got mem_we=%b want 0", mem_we);
                end
            end
        end
        n_checks++;
        if (array_clear !== 1'b1 || array_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_phase: got clr=%b start=%b busy=%b want 1 0 1", array_clear, array_start, busy);
        end
        step();
        n_checks++;
        if (array_start !== 1'b1 || array_clear !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL start_phase: got start=%b clr=%b we=%b want 1 0 0", array_start, array_clear, mem_we);
        end
    endtask

    // pattern 0: ready always high; 1: ready 1,0,0 repeating.
    task automatic run_output(input int pattern, input int stop_after, input int pause_at, input bit inject);
        int t, cyc, accepted;
        bit paused, r;
        t = 0;
        while (!out_valid && t < 40) begin
            in_valid = inject && t[0];
            step();
            if (inject) begin
                n_checks++;
                if (mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_ignore_in_valid: got mem_we=%b want 0", mem_we);
                end
            end
            t++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_timeout: got out_valid=%b want 1 within 40 cycles", out_valid);
            return;
        end
        cyc = 0;
        accepted = 0;
        paused = 0;
        while (sb.size() > 0 && cyc < 200) begin
            if (accepted == pause_at && !paused) begin
                logic [11:0] snap;
                snap = {out_data, out_valid, result_idx, busy};
                ena = 1'b0;
                out_ready = 1'b1;
                for (int p = 0; p < 5; p++) begin
                    step();
                    n_checks++;
                    if ({out_data, out_valid, result_idx, busy} !== snap) begin
                        n_fail++;
                        $display("FAIL out_ena_hold: got %h want %h", {out_data, out_valid, result_idx, busy}, snap);
                    end
                end
                ena = 1'b1;
                out_ready = 1'b0;
                paused = 1;
            end
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== sb[0]) begin
                n_fail++;
                $display("FAIL out_byte[%0d]: got valid=%b data=%h want valid=1 data=%h", accepted, out_valid, out_data, sb[0]);
            end
            if (accepted == stop_after) begin
                out_ready = 1'b0;
                return;
            end
            r = (pattern == 0) || (cyc % 3 == 0);
            out_ready = r;
            in_valid = inject && cyc[0] && sb.size() > 1;
            step();
            in_valid = 1'b0;
            if (inject) begin
                n_checks++;
                if (mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL out_ignore_in_valid: got mem_we=%b want 0", mem_we);
                end
            end
            if (r) begin
                void'(sb.pop_front());
                accepted++;
            end
            cyc++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL out_timeout: got %0d bytes left want 0", sb.size());
            return;
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_single: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    logic [7:0] basic_ops[8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    logic [7:0] basic_exp[8] = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};

    task automatic test_reset;
        step();
        step();
        check_all_zero("reset_held");
        rst_n = 1'b1;
        step();
        check_all_zero("reset_released_idle");
    endtask

    task automatic test_basic;
        push_bytes(basic_exp);
        load_ops(basic_ops, 1, -1);
        run_output(0, -1, -1, 0);
    endtask

    task automatic test_negative;
        logic [7:0] ops[8] = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
`ifdef TPU_RELU_EN
        logic [7:0] exp_b[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`else
        logic [7:0] exp_b[8] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`endif
        push_bytes(exp_b);
        load_ops(ops, 1, -1);
        run_output(0, -1, -1, 0);
    endtask

    task automatic test_backpressure;
        logic [7:0] ops[8];
        for (int k = 0; k < 8; k++) ops[k] = 8'($urandom_range(0, 255));
        push_model(ops);
        load_ops(ops, 1, -1);
        run_output(1, -1, -1, 0);
    endtask

    task automatic test_gapped_ignored;
        logic [7:0] ops[8];
        for (int k = 0; k < 8; k++) ops[k] = 8'($urandom_range(0, 255));
        push_model(ops);
        load_ops(ops, 3, -1);
        run_output(0, -1, -1, 1);
    endtask

    task automatic test_reset_mid;
        push_bytes(basic_exp);
        load_ops(basic_ops, 1, -1);
        run_output(0, 3, -1, 0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_async");
        sb.delete();
        step();
        check_all_zero("reset_mid_held");
        rst_n = 1'b1;
        test_basic();
    endtask

    task automatic test_ena;
        push_bytes(basic_exp);
        load_ops(basic_ops, 1, 3);
        run_output(0, -1, 4, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_gapped_ignored();
        test_reset_mid();
        test_ena();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tpu_seq_ctrl.md
# tpu_seq_ctrl

Top-level sequencer for the 2×2 TPU behind the `tt_um_tpu` pin wrapper.
- Accepts operand bytes from the dedicated inputs and writes them into the operand buffer.
- Clears and starts the systolic MAC array, then waits for its done flag.
- Streams the 16-bit results back out over the dedicated outputs with a valid/ready handshake.

It sits between the pin wrapper and the array/operand buffer. It owns all sequencing; the array owns no control state beyond its own compute.

## Interface
- `N`, 2: matrix dimension; operand count per matrix is N*N.
- `DATA_W`, 8: operand and pin byte width.
- `ACC_W`, 16: result width, signed two's complement; must equal 2*DATA_W.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  design enable; when low, the FSM, counters and registered outputs hold.
- `in_data`  in  8  operand byte (from `ui_in`).
- `in_valid`  in  1  operand byte strobe (from `uio_in[0]`).
- `out_ready`  in  1  host accepts the current output byte (from `uio_in[1]`).
- `out_data`  out  8  result byte (to `uo_out`).
- `out_valid`  out  1  `out_data` is valid.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result byte is accepted.
- `mem_we`  out  1  operand buffer write enable.
- `mem_addr`  out  3  buffer address: 0–3 are A row-major, 4–7 are B row-major.
- `mem_wdata`  out  8  buffer write data.
- `array_clear`  out  1  clears the accumulators.
- `array_start`  out  1  one-cycle compute start pulse.
- `array_done`  in  1  array finished; level signal, held until the next clear.
- `result_idx`  out  2  selects the array result: 0=C00, 1=C01, 2=C10, 3=C11.
- `result_in`  in  16  selected result, combinational from the array.

## Operation
- **States:** IDLE, LOAD, CLEAR, START, WAIT, OUTPUT.
- **IDLE:**
  - Nothing is written.
  - `in_valid` moves to LOAD, and that byte is written as byte 0.
- **LOAD:**
  - Each sampled `in_valid` writes `in_data` to `mem_addr = load_cnt`, then increments `load_cnt`.
  - After byte 7 is written, go to CLEAR.
- **CLEAR:**
  - `array_clear=1` for exactly 1 cycle, then go to START.
- **START:**
  - `array_start=1` for exactly 1 cycle, then go to WAIT.
- **WAIT:**
  - Hold until `array_done=1`, then go to OUTPUT with `byte_cnt=0`.
- **OUTPUT:**
  - `result_idx = byte_cnt[2:1]`; `out_valid=1`.
  - `out_data` = `result_in[15:8]` when `byte_cnt[0]=0`, else `result_in[7:0]` (high byte first).
  - `byte_cnt` increments on `out_valid && out_ready`.
  - When byte 7 is accepted: go to IDLE and pulse `done` for one cycle.
- **Ignored inputs:**
  - `in_valid` is ignored in CLEAR, START, WAIT and OUTPUT.
  - `out_ready` is ignored outside OUTPUT.
- **Counters:** `load_cnt` and `byte_cnt` are 3 bits. They reset to 0 on every IDLE entry and never wrap mid-transaction.
- **Reset:**
  - Asserting `rst_n` low at any time forces IDLE immediately (asynchronously) and zeroes the counters.
  - Operands already written stay in the buffer; the array is not cleared until the next CLEAR state.
- **`ena` low:**
  - Freezes state, counters and all outputs.
  - `in_valid` and `out_ready` are not sampled.

## Timing
- **Reset values:** all outputs are 0 (`out_data`, `out_valid`, `busy`, `done`, `mem_*`, `array_*`, `result_idx`).
- **Buffer writes:** `mem_we`, `mem_addr` and `mem_wdata` are registered. They appear the cycle after `in_valid` is sampled and last 1 cycle.
- **Back-to-back input:** `in_valid` may be high every cycle, giving 8 writes in 8 consecutive cycles.
- **Load to start:** CLEAR begins the cycle after byte 7 is sampled; `array_start` follows one cycle after `array_clear`.
- **Done to output:** `out_valid` rises the cycle after `array_done` is sampled high.
- **Output path:** `out_data` is combinational from `result_in` and `byte_cnt`, and is stable while `out_ready` is low.
- **Output throughput:** one byte per cycle while `out_ready` is held high.
- **Minimum transaction:** 8 (load) + 1 (CLEAR) + 1 (START) + array latency + 8 (output) cycles.

## Configuration
- **`TPU_RELU_EN` defined:**
  - Each result is clamped to 0 when `result_in[15]=1` before byte selection, so both bytes read 0x00.
  - Non-negative results pass through unchanged.
- **`TPU_RELU_EN` undefined:** raw signed results are output.

## Structure
- **Package `tpu_pkg`:**
  - State enum `tpu_state_t`.
  - `TPU_N`, `TPU_DATA_W`, `TPU_ACC_W`.
  - Address constants `A_BASE=0`, `B_BASE=4`.
- **Sub-module `tpu_out_ser`:** the output byte serializer.
  - Contains `byte_cnt`, the handshake, high/low byte selection and ReLU.
  - Takes a start pulse and returns a last-accept pulse.
- FSM, load counter and array strobes stay in `tpu_seq_ctrl`.

## Test plan
- **Basic multiply:** load A=[[1,2],[3,4]], B=[[5,6],[7,8]]; bench array model raises `array_done` 4 cycles after start.
  - Output bytes: 00 13 00 16 00 2B 00 32.
  - `done` pulses once, then `busy=0`.
- **Negative result, with and without ReLU:** A=[[-1,0],[0,1]], B=identity.
  - Without `TPU_RELU_EN`: C00 bytes are FF FF.
  - With it: 00 00, and C11 bytes are 00 01.
- **Output backpressure:** `out_ready` toggles 1,0,0,1,…
  - `out_data` holds during low cycles.
  - All 8 bytes arrive in order; none are duplicated or skipped.
- **Gapped input with ignored strobes:**
  - `in_valid` high every third cycle: 8 writes at `mem_addr` 0–7 in order.
  - Extra `in_valid` pulses during WAIT and OUTPUT produce no `mem_we`.
- **Reset mid-operation:** pull `rst_n` low during OUTPUT at byte 3.
  - All outputs go to 0 immediately.
  - A subsequent full transaction produces correct results.
- **`ena` low:** drop `ena` for 5 cycles during LOAD and again during OUTPUT.
  - No state or counter change while low.
  - Final results are identical to the basic multiply test.
